// File: rtl/config_chain_pkg.sv
// config_chain_pkg: shared state encoding and byte width for the configuration chain loader.
package config_chain_pkg;
    localparam int CFG_BYTE_W = 8;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_t;
endpackage

// File: rtl/cfg_clk_divider.sv
// cfg_clk_divider: half-period counter for prog_clk generation.
//   CK, RST    : system clock, async active-high reset
//   restart    : holds the counter at zero so the next phase starts fresh
//   phase_end  : high in the last CK cycle of each CLK_DIV-cycle phase
module cfg_clk_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic CK,
    input  logic RST,
    input  logic restart,
    output logic phase_end
);
    localparam int CW = $clog2(CLK_DIV + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        phase_end = !restart && (cnt_q == CW'(CLK_DIV - 1));
        cnt_d     = (restart || phase_end) ? '0 : cnt_q + CW'(1);
    end
    always_ff @(posedge CK or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/config_chain_loader.sv
// config_chain_loader: serialises bitstream bytes LSB-first onto the config chain and captures readback.
//   CK, RST               : system clock, async active-high reset
//   start                 : begin a load (honoured in IDLE/DONE)
//   in_data/in_valid/ready: byte source handshake, ready only in LOAD
//   prog_clk, ccff_head   : registered chain clock and head data
//   ccff_tail             : chain tail, sampled on each prog_clk rise edge
//   busy, done            : activity / completion levels
//   tail_data/tail_valid  : readback byte and its one-cycle strobe
//   bit_count             : bits shifted in the current or last load
module config_chain_loader
    import config_chain_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int CLK_DIV   = 2
) (
    input  logic                          CK,
    input  logic                          RST,
    input  logic                          start,
    input  logic [CFG_BYTE_W-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          prog_clk,
    output logic                          ccff_head,
    input  logic                          ccff_tail,
    output logic                          busy,
    output logic                          done,
    output logic [CFG_BYTE_W-1:0]         tail_data,
    output logic                          tail_valid,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
);
    localparam int BCW = $clog2(CHAIN_LEN + 1);
    localparam int IW  = $clog2(CFG_BYTE_W);

    state_t                state_q, state_d;
    logic [CFG_BYTE_W-1:0] data_q, data_d;
    logic [IW-1:0]         bit_idx_q, bit_idx_d;
    logic                  ccff_head_q, ccff_head_d;
    logic                  prog_clk_q, prog_clk_d;
    logic [BCW-1:0]        bit_count_q, bit_count_d;
    logic [CFG_BYTE_W-1:0] tail_sh_q, tail_sh_d;
    logic                  tail_fire_q, tail_fire_d;
    logic                  tail_valid_q, tail_valid_d;
    logic [CFG_BYTE_W-1:0] tail_data_q, tail_data_d;
    logic                  phase_end, div_restart, last_bit, byte_end;

    // The divider only runs while shifting; LOAD/IDLE/DONE hold it at zero so
    // every SHIFT_LO starts with a full CLK_DIV-cycle phase.
    assign div_restart = !(state_q == SHIFT_LO || state_q == SHIFT_HI);

    cfg_clk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .CK        (CK),
        .RST       (RST),
        .restart   (div_restart),
        .phase_end (phase_end)
    );

    // bit_count counts completed bits, so it equals CHAIN_LEN-1 while the final bit is in flight.
    assign last_bit = (bit_count_q == BCW'(CHAIN_LEN - 1));
    assign byte_end = (bit_idx_q == IW'(CFG_BYTE_W - 1));

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            data_q       <= '0;
            bit_idx_q    <= '0;
            ccff_head_q  <= 1'b0;
            prog_clk_q   <= 1'b0;
            bit_count_q  <= '0;
            tail_sh_q    <= '0;
            tail_fire_q  <= 1'b0;
            tail_valid_q <= 1'b0;
            tail_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            bit_idx_q    <= bit_idx_d;
            ccff_head_q  <= ccff_head_d;
            prog_clk_q   <= prog_clk_d;
            bit_count_q  <= bit_count_d;
            tail_sh_q    <= tail_sh_d;
            tail_fire_q  <= tail_fire_d;
            tail_valid_q <= tail_valid_d;
            tail_data_q  <= tail_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: state_d = start ? LOAD : state_q;
            LOAD:       state_d = in_valid ? SHIFT_LO : LOAD;
            SHIFT_LO:   state_d = phase_end ? SHIFT_HI : SHIFT_LO;
            SHIFT_HI:   state_d = !phase_end ? SHIFT_HI : last_bit ? DONE : byte_end ? LOAD : SHIFT_LO;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d       = data_q;
        bit_idx_d    = bit_idx_q;
        ccff_head_d  = ccff_head_q;
        bit_count_d  = bit_count_q;
        tail_sh_d    = tail_sh_q;
        tail_fire_d  = 1'b0;
        // The strobe follows the completing sample by exactly one edge.
        tail_valid_d = tail_fire_q;
        tail_data_d  = tail_fire_q ? tail_sh_q : tail_data_q;
        prog_clk_d   = (state_d == SHIFT_HI);
        if ((state_q == IDLE || state_q == DONE) && start) bit_count_d = '0;
        if (state_q == LOAD && in_valid) begin
            data_d      = in_data;
            bit_idx_d   = '0;
            ccff_head_d = in_data[0];
            tail_sh_d   = '0;
        end
        // The edge entering SHIFT_HI is the prog_clk rise: the tail still shows the pre-shift bit.
        if (state_q == SHIFT_LO && phase_end) begin
            tail_sh_d[bit_idx_q] = ccff_tail;
            tail_fire_d          = byte_end || last_bit;
        end
        if (state_q == SHIFT_HI && phase_end) begin
            bit_count_d = bit_count_q + BCW'(1);
            if (!last_bit && !byte_end) begin
                bit_idx_d   = bit_idx_q + IW'(1);
                ccff_head_d = data_q[bit_idx_q + IW'(1)];
            end
        end
    end

    always_comb begin
        in_ready   = (state_q == LOAD);
        busy       = (state_q == LOAD || state_q == SHIFT_LO || state_q == SHIFT_HI);
        done       = (state_q == DONE);
        prog_clk   = prog_clk_q;
        ccff_head  = ccff_head_q;
        tail_data  = tail_data_q;
        tail_valid = tail_valid_q;
        bit_count  = bit_count_q;
    end
endmodule

// File: tb/tb_config_chain_loader.sv
// tb_config_chain_loader: table-driven check of three loader configurations against chain models.
module tb_config_chain_loader;
    localparam int N = 3;
    localparam int LENS[N] = '{12, 16, 8};
    localparam int DIVS[N] = '{1, 3, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst, start, in_valid, in_ready, prog_clk, ccff_head, ccff_tail, busy, done, tail_valid, preload;
    logic [7:0]   in_data   [N];
    logic [7:0]   tail_data [N];
    logic [4:0]   bit_count [N];
    logic [15:0]  chain     [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = LENS[g];
        logic [$clog2(L+1)-1:0] bc;
        logic [L-1:0]           model;
        logic                   pclk_prev;
        config_chain_loader #(.CHAIN_LEN(L), .CLK_DIV(DIVS[g])) dut (
            .CK(clk), .RST(rst[g]), .start(start[g]), .in_data(in_data[g]),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .prog_clk(prog_clk[g]),
            .ccff_head(ccff_head[g]), .ccff_tail(ccff_tail[g]), .busy(busy[g]),
            .done(done[g]), .tail_data(tail_data[g]), .tail_valid(tail_valid[g]),
            .bit_count(bc)
        );
        assign bit_count[g] = 5'(bc);
        assign ccff_tail[g] = model[0];
        assign chain[g]     = 16'(model);
        // Chain of L flops: head enters the top, bit 0 is the tail; shifts once per prog_clk rise.
        always @(posedge clk) begin
            pclk_prev <= prog_clk[g];
            if (preload[g]) model <= '1;
            else if (prog_clk[g] && !pclk_prev) model <= {ccff_head[g], model[L-1:1]};
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_reset(input int i, input string tag);
        check($sformatf("%s_ctl%0d", tag, i),
              {26'd0, prog_clk[i], ccff_head[i], in_ready[i], busy[i], done[i], tail_valid[i]}, 32'd0);
        check($sformatf("%s_tail_data%0d", tag, i), 32'(tail_data[i]), 32'd0);
        check($sformatf("%s_bit_count%0d", tag, i), 32'(bit_count[i]), 32'd0);
    endtask

    typedef struct {
        int         inst;
        logic [7:0] b0, b1;
        int         stall;
        logic       pre;
        int         exp_cycles, exp_hs;
        logic [15:0] exp_heads;
        int         exp_gap, exp_ntail;
        logic [7:0] exp_t0, exp_t1;
        logic [15:0] exp_chain;
        int         exp_bc;
    } vec_t;

    task automatic run_load(input int r, input vec_t v);
        int i, c, hs, nb, nr, nt, run, maxgap, since_chg, stall_left;
        logic ok, prev_p, prev_h, last_rise_h;
        logic [15:0] heads;
        logic [7:0]  tails [2];
        i = v.inst;
        c = 0; hs = 0; nb = 0; nr = 0; nt = 0; run = 0; maxgap = 0; since_chg = 0;
        stall_left = v.stall; ok = 1'b1; heads = '0; tails[0] = '0; tails[1] = '0;
        if (v.pre) begin
            preload[i] = 1'b1;
            @(negedge clk);
            preload[i] = 1'b0;
        end
        @(negedge clk) start[i] = 1'b1;
        @(negedge clk) start[i] = 1'b0;
        check($sformatf("r%0d_start_bc", r), 32'(bit_count[i]), 32'd0);
        check($sformatf("r%0d_start_ready", r), 32'(in_ready[i]), 32'd1);
        prev_p = prog_clk[i];
        prev_h = ccff_head[i];
        last_rise_h = 1'b0;
        while (!done[i] && c < 3000) begin
            if (in_ready[i]) begin
                if (nr > 0 && ccff_head[i] !== last_rise_h) ok = 1'b0;
                if (nb == 1 && stall_left > 0) begin
                    in_valid[i] = 1'b0;
                    stall_left--;
                end else begin
                    in_valid[i] = 1'b1;
                    in_data[i]  = (nb == 0) ? v.b0 : v.b1;
                    hs++;
                    nb++;
                end
            end
            @(negedge clk);
            c++;
            if (ccff_head[i] !== prev_h) begin
                since_chg = 0;
                if (prog_clk[i]) ok = 1'b0;
            end else since_chg++;
            if (prog_clk[i] === prev_p) run++;
            else begin
                if (prev_p && run != DIVS[i]) ok = 1'b0;
                if (!prev_p && nr > 0 && run > maxgap) maxgap = run;
                run = 1;
                if (prog_clk[i]) begin
                    if (nr < 16) heads[nr] = ccff_head[i];
                    nr++;
                    last_rise_h = ccff_head[i];
                    if (since_chg < DIVS[i]) ok = 1'b0;
                end
            end
            if (tail_valid[i]) begin
                if (nt < 2) tails[nt] = tail_data[i];
                nt++;
            end
            prev_p = prog_clk[i];
            prev_h = ccff_head[i];
        end
        in_valid[i] = 1'b0;
        check($sformatf("r%0d_done_cycle", r), 32'(c), 32'(v.exp_cycles));
        check($sformatf("r%0d_handshakes", r), 32'(hs), 32'(v.exp_hs));
        check($sformatf("r%0d_rises", r), 32'(nr), 32'(LENS[i]));
        check($sformatf("r%0d_head_bits", r), 32'(heads), 32'(v.exp_heads));
        check($sformatf("r%0d_phase_timing", r), 32'(ok), 32'd1);
        check($sformatf("r%0d_max_low_gap", r), 32'(maxgap), 32'(v.exp_gap));
        check($sformatf("r%0d_tail_strobes", r), 32'(nt), 32'(v.exp_ntail));
        check($sformatf("r%0d_tail0", r), 32'(tails[0]), 32'(v.exp_t0));
        check($sformatf("r%0d_tail1", r), 32'(tails[1]), 32'(v.exp_t1));
        check($sformatf("r%0d_chain", r), 32'(chain[i]), 32'(v.exp_chain));
        check($sformatf("r%0d_bit_count", r), 32'(bit_count[i]), 32'(v.exp_bc));
        check($sformatf("r%0d_done_pclk", r), {30'd0, prog_clk[i], done[i]}, 32'd1);
    endtask

    vec_t vecs [4];

    initial begin
        int c, bc0, seen_done;
        vecs[0] = '{inst: 0, b0: 8'hA5, b1: 8'h0F, stall: 0, pre: 1'b1, exp_cycles: 26, exp_hs: 2,
                    exp_heads: 16'h0FA5, exp_gap: 2, exp_ntail: 2, exp_t0: 8'hFF, exp_t1: 8'h0F,
                    exp_chain: 16'h0FA5, exp_bc: 12};
        vecs[1] = '{inst: 1, b0: 8'h3C, b1: 8'hC3, stall: 5, pre: 1'b1, exp_cycles: 103, exp_hs: 2,
                    exp_heads: 16'hC33C, exp_gap: 9, exp_ntail: 2, exp_t0: 8'hFF, exp_t1: 8'hFF,
                    exp_chain: 16'hC33C, exp_bc: 16};
        vecs[2] = '{inst: 2, b0: 8'h5A, b1: 8'h00, stall: 0, pre: 1'b1, exp_cycles: 33, exp_hs: 1,
                    exp_heads: 16'h005A, exp_gap: 2, exp_ntail: 1, exp_t0: 8'hFF, exp_t1: 8'h00,
                    exp_chain: 16'h005A, exp_bc: 8};
        vecs[3] = '{inst: 2, b0: 8'h5A, b1: 8'h00, stall: 0, pre: 1'b0, exp_cycles: 33, exp_hs: 1,
                    exp_heads: 16'h005A, exp_gap: 2, exp_ntail: 1, exp_t0: 8'h5A, exp_t1: 8'h00,
                    exp_chain: 16'h005A, exp_bc: 8};
        rst = '1; start = '0; in_valid = '0; preload = '0;
        for (int i = 0; i < N; i++) in_data[i] = 8'h00;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) check_reset(i, "por");
        rst = '0;

        // in_valid in IDLE must not consume anything or move the FSM.
        in_valid[0] = 1'b1; in_data[0] = 8'hFF;
        repeat (4) @(negedge clk);
        check("idle_valid_ctl", {28'd0, in_ready[0], busy[0], prog_clk[0], done[0]}, 32'd0);
        check("idle_valid_bc", 32'(bit_count[0]), 32'd0);
        in_valid[0] = 1'b0;

        // Reset after 5 bits of a 16-bit load.
        @(negedge clk) start[1] = 1'b1;
        @(negedge clk) start[1] = 1'b0;
        in_valid[1] = 1'b1; in_data[1] = 8'h3C;
        c = 0;
        while (bit_count[1] != 5'd5 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("rst_reach_5_bits", 32'(bit_count[1]), 32'd5);
        #2 rst[1] = 1'b1;
        #1 check_reset(1, "midrst");
        seen_done = 0;
        repeat (3) @(negedge clk) if (done[1]) seen_done++;
        rst[1] = 1'b0;
        repeat (20) @(negedge clk) if (done[1] || busy[1]) seen_done++;
        check("midrst_no_done", 32'(seen_done), 32'd0);
        in_valid[1] = 1'b0;

        for (int r = 0; r < 4; r++) run_load(r, vecs[r]);

        // start during SHIFT_HI is ignored: no clear, no return to LOAD.
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        in_valid[0] = 1'b1; in_data[0] = 8'hA5;
        c = 0;
        while (!(prog_clk[0] && bit_count[0] == 5'd3) && c < 100) begin
            @(negedge clk);
            c++;
        end
        bc0 = int'(bit_count[0]);
        check("busy_start_reached_hi", {31'd0, prog_clk[0]}, 32'd1);
        start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        check("busy_start_state", {30'd0, busy[0], in_ready[0]}, 32'd2);
        check("busy_start_bc", 32'(bit_count[0]), 32'(bc0 + 1));
        c = 0;
        while (!done[0] && c < 100) begin
            if (in_ready[0]) in_data[0] = 8'h0F;
            @(negedge clk);
            c++;
        end
        in_valid[0] = 1'b0;
        check("busy_start_final_bc", 32'(bit_count[0]), 32'd12);
        check("busy_start_chain", 32'(chain[0]), 32'h0FA5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
